halt_dump_unit: RTL

HALT_DUMP_UNIT -- requirements
Module: halt_dump_unit

---
 rtl/halt_dump_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/halt_dump_unit.sv
// Post-halt state dump: streams the register file then data memory over a
// valid/ready port, one word per cycle when the sink keeps ready high.
module halt_dump_unit #(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 1024,
    parameter int MAW       = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           halt,
    output logic [4:0]     rf_addr,
    input  logic [31:0]    rf_data,
    output logic [MAW-1:0] dm_addr,
    input  logic [31:0]    dm_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic           out_sel,
    output logic           out_last,
    output logic           busy,
    output logic           done
);

    // One spare bit so the index can reach MEM_WORDS, marking memory exhausted
    localparam int IW = ((MAW > 5) ? MAW : 5) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REGS = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          words_left;
    logic          load;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;

        words_left = (state_q == S_REGS) ||
                     ((state_q == S_MEM) && (idx_q != IW'(MEM_WORDS)));
        // Reload in the same cycle the current word drains, so no bubbles
        load = words_left && (!valid_q || out_ready);

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_REGS;
                    idx_d   = '0;
                end
            end
            S_REGS: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = rf_data;
                    sel_d   = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == IW'(NUM_REGS - 1)) begin
                        state_d = S_MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_MEM: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = dm_data;
                    sel_d   = 1'b1;
                    last_d  = (idx_q == IW'(MEM_WORDS - 1));
                    idx_d   = idx_q + IW'(1);
                end else if (valid_q && out_ready && last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!halt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign rf_addr   = (state_q == S_REGS) ? idx_q[4:0] : '0;
    assign dm_addr   = (state_q == S_MEM) ? idx_q[MAW-1:0] : '0;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_REGS) || (state_q == S_MEM) || valid_q;
    assign done      = (state_q == S_DONE);

endmodule
